alu_issue_sequencer: RTL and testbench



---
 rtl/alu_seq_pkg.sv | 43 ++++
 rtl/alu_issue_sequencer_decode.sv | 47 ++++
 rtl/alu_issue_sequencer.sv | 146 ++++++++++++++
 tb/tb_alu_issue_sequencer.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU issue sequencer.
//   - opcode encodings of the decoded instruction set
//   - ALU control code enum (alu_control output encoding)
//   - latency class selector and sequencer state enum
package alu_seq_pkg;

  localparam logic [4:0] OP_ADD  = 5'b11000;
  localparam logic [4:0] OP_JMP  = 5'b00001;
  localparam logic [4:0] OP_JEQ  = 5'b00111;
  localparam logic [4:0] OP_SUB  = 5'b11010;
  localparam logic [4:0] OP_CMPR = 5'b10110;
  localparam logic [4:0] OP_CMPI = 5'b10111;
  localparam logic [4:0] OP_MUL  = 5'b11110;
  localparam logic [4:0] OP_MOD  = 5'b11100;
  localparam logic [4:0] OP_LSR  = 5'b11001;
  localparam logic [4:0] OP_MOVR = 5'b10100;
  localparam logic [4:0] OP_MOVI = 5'b10101;

  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_MUL  = 3'b010,
    ALU_MOD  = 3'b011,
    ALU_LSR  = 3'b100,
    ALU_MOV  = 3'b101,
    ALU_NONE = 3'b111
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    LAT_ONE = 2'd0,
    LAT_MUL = 2'd1,
    LAT_MOD = 2'd2
  } lat_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_issue_sequencer_decode.sv
// alu_op_decode: purely combinational opcode decoder.
//   opcode_i      : 5-bit instruction opcode
//   alu_control_o : ALU operation select (ALU_NONE for undecodable opcodes)
//   wb_en_o       : op writes a register
//   flag_we_o     : op updates the zero flag (compares)
//   is_jump_o     : unconditional jump
//   is_jeq_o      : jump when zero flag set
//   illegal_o     : opcode not in the instruction set
//   lat_sel_o     : execution latency class
module alu_op_decode
  import alu_seq_pkg::*;
(
  input  logic [4:0] opcode_i,
  output alu_ctrl_e  alu_control_o,
  output logic       wb_en_o,
  output logic       flag_we_o,
  output logic       is_jump_o,
  output logic       is_jeq_o,
  output logic       illegal_o,
  output lat_sel_e   lat_sel_o
);

  always_comb begin
    alu_control_o = ALU_NONE;
    wb_en_o       = 1'b0;
    flag_we_o     = 1'b0;
    is_jump_o     = 1'b0;
    is_jeq_o      = 1'b0;
    illegal_o     = 1'b0;
    lat_sel_o     = LAT_ONE;
    case (opcode_i)
      OP_ADD:  begin alu_control_o = ALU_ADD; wb_en_o = 1'b1; end
      OP_JMP:  begin alu_control_o = ALU_ADD; is_jump_o = 1'b1; end
      OP_JEQ:  begin alu_control_o = ALU_ADD; is_jeq_o = 1'b1; end
      OP_SUB:  begin alu_control_o = ALU_SUB; wb_en_o = 1'b1; end
      OP_CMPR: begin alu_control_o = ALU_SUB; flag_we_o = 1'b1; end
      OP_CMPI: begin alu_control_o = ALU_SUB; flag_we_o = 1'b1; end
      OP_MUL:  begin alu_control_o = ALU_MUL; wb_en_o = 1'b1; lat_sel_o = LAT_MUL; end
      OP_MOD:  begin alu_control_o = ALU_MOD; wb_en_o = 1'b1; lat_sel_o = LAT_MOD; end
      OP_LSR:  begin alu_control_o = ALU_LSR; wb_en_o = 1'b1; end
      OP_MOVR: begin alu_control_o = ALU_MOV; wb_en_o = 1'b1; end
      OP_MOVI: begin alu_control_o = ALU_MOV; wb_en_o = 1'b1; end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_sequencer.sv
// alu_issue_sequencer: execute-stage controller between decode and the ALU.
// Accepts one opcode per in_valid/in_ready handshake, holds alu_control for
// the op latency (MUL_LAT / MOD_LAT for multi-cycle ops, else 1), then
// presents a completion record under out_valid/out_ready.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : opcode handshake, in_opcode the 5-bit opcode
//   alu_zero            : ALU zero result, sampled on the last EXEC cycle
//   alu_control         : ALU operation select (111 when idle)
//   out_valid/out_ready : completion record handshake
//   wb_en, flag_we, branch_taken, illegal : record fields (0 when !out_valid)
//   z_flag              : architectural zero flag
// Build option: ALU_SEQ_BACK2BACK_EN lets DONE accept the next opcode in the
// same cycle its record is consumed.
module alu_issue_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned MUL_LAT = 3,
  parameter int unsigned MOD_LAT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [4:0] in_opcode,
  input  logic       alu_zero,
  output logic [2:0] alu_control,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       wb_en,
  output logic       flag_we,
  output logic       z_flag,
  output logic       branch_taken,
  output logic       illegal
);

  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] MOD_CNT = CNT_W'(MOD_LAT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             z_flag_q, z_flag_d;
  logic             br_q, br_d;
  logic             accept;
  logic [CNT_W-1:0] load_cnt;
  alu_ctrl_e        ctrl_c;

  alu_ctrl_e dec_ctrl;
  logic      dec_wb, dec_fwe, dec_jump, dec_jeq, dec_ill;
  lat_sel_e  dec_lat;

  // Decoded attributes of the op in flight, captured at accept.
  alu_ctrl_e op_ctrl_q;
  logic      op_wb_q, op_fwe_q, op_jump_q, op_jeq_q, op_ill_q;

  alu_op_decode u_dec (
    .opcode_i      (in_opcode),
    .alu_control_o (dec_ctrl),
    .wb_en_o       (dec_wb),
    .flag_we_o     (dec_fwe),
    .is_jump_o     (dec_jump),
    .is_jeq_o      (dec_jeq),
    .illegal_o     (dec_ill),
    .lat_sel_o     (dec_lat)
  );

  always_comb begin
    case (dec_lat)
      LAT_MUL: load_cnt = MUL_CNT;
      LAT_MOD: load_cnt = MOD_CNT;
      default: load_cnt = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      z_flag_q <= 1'b0;
      br_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      z_flag_q <= z_flag_d;
      br_q     <= br_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      op_ctrl_q <= dec_ctrl;
      op_wb_q   <= dec_wb;
      op_fwe_q  <= dec_fwe;
      op_jump_q <= dec_jump;
      op_jeq_q  <= dec_jeq;
      op_ill_q  <= dec_ill;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    z_flag_d  = z_flag_q;
    br_d      = br_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    ctrl_c    = ALU_NONE;
    case (state_q)
      ST_IDLE: in_ready = 1'b1;
      ST_EXEC: begin
        ctrl_c = op_ctrl_q;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = ST_DONE;
          if (op_fwe_q) z_flag_d = alu_zero;
          // JEQ resolves against the flag as it stands now; a JEQ never
          // updates the flag itself, so no forwarding from alu_zero.
          br_d = op_jump_q | (op_jeq_q & z_flag_q);
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = ST_IDLE;
`ifdef ALU_SEQ_BACK2BACK_EN
          in_ready = 1'b1;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
    accept = in_valid & in_ready;
    if (accept) begin
      state_d = ST_EXEC;
      cnt_d   = load_cnt;
    end
  end

  assign alu_control  = ctrl_c;
  assign z_flag       = z_flag_q;
  assign wb_en        = out_valid & op_wb_q;
  assign flag_we      = out_valid & op_fwe_q;
  assign illegal      = out_valid & op_ill_q;
  assign branch_taken = out_valid & br_q;

endmodule

// File: tb/tb_alu_issue_sequencer.sv
module tb_alu_issue_sequencer;

  localparam int MUL_L = 3;
  localparam int MOD_L = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready;
  logic [4:0] in_opcode;
  logic       alu_zero;
  logic [2:0] alu_control;
  logic       out_valid, out_ready;
  logic       wb_en, flag_we, z_flag, branch_taken, illegal;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  logic model_z = 1'b0;
  logic [3:0] sb[$];   // expected {wb_en, flag_we, branch_taken, illegal}

  alu_issue_sequencer #(.MUL_LAT(MUL_L), .MOD_LAT(MOD_L)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .alu_zero(alu_zero), .alu_control(alu_control),
    .out_valid(out_valid), .out_ready(out_ready), .wb_en(wb_en),
    .flag_we(flag_we), .z_flag(z_flag), .branch_taken(branch_taken),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] model_ctrl(input logic [4:0] op);
    case (op)
      5'b11000, 5'b00001, 5'b00111: return 3'b000;
      5'b11010, 5'b10110, 5'b10111: return 3'b001;
      5'b11110:                     return 3'b010;
      5'b11100:                     return 3'b011;
      5'b11001:                     return 3'b100;
      5'b10100, 5'b10101:           return 3'b101;
      default:                      return 3'b111;
    endcase
  endfunction

  function automatic int model_lat(input logic [4:0] op);
    if (op == 5'b11110) return MUL_L;
    if (op == 5'b11100) return MOD_L;
    return 1;
  endfunction

  function automatic logic [3:0] model_rec(input logic [4:0] op, input logic z);
    case (op)
      5'b11000, 5'b11010, 5'b11110, 5'b11100,
      5'b11001, 5'b10100, 5'b10101: return 4'b1000;
      5'b10110, 5'b10111:           return 4'b0100;
      5'b00001:                     return 4'b0010;
      5'b00111:                     return {2'b00, z, 1'b0};
      default:                      return 4'b0001;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [4:0] op, input logic zero, input int hold);
    logic [3:0] exp_rec;
    int lat, cyc;
    lat = model_lat(op);
    out_ready = (hold == 0);
    chk("idle_in_ready", in_ready, 1);
    chk("idle_ctrl", alu_control, 3'b111);
    in_opcode = op;
    in_valid  = 1'b1;
    sb.push_back(model_rec(op, model_z));
    step();
    in_valid = 1'b0;
    for (int i = 1; i <= lat; i++) begin
      chk("exec_ctrl", alu_control, model_ctrl(op));
      chk("exec_in_ready", in_ready, 0);
      chk("exec_out_valid", out_valid, 0);
      if (i == lat) alu_zero = zero;
      step();
      alu_zero = 1'b0;
    end
    if (op == 5'b10110 || op == 5'b10111) model_z = zero;
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      step();
      cyc++;
    end
    chk("done_latency", cyc, 0);
    exp_rec = sb.pop_front();
    for (int k = 0; k <= hold; k++) begin
      chk("done_out_valid", out_valid, 1);
      chk("done_ctrl", alu_control, 3'b111);
      chk("done_record", {wb_en, flag_we, branch_taken, illegal}, exp_rec);
      chk("done_z_flag", z_flag, model_z);
      if (k < hold) begin
        chk("bp_in_ready", in_ready, 0);
        step();
      end
    end
    out_ready = 1'b1;
    step();
    chk("idle_out_valid", out_valid, 0);
    chk("idle_record", {wb_en, flag_we, branch_taken, illegal}, 4'b0000);
    chk("idle_in_ready_after", in_ready, 1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_opcode = 5'b0; alu_zero = 1'b0; out_ready = 1'b1;
    step();
    step();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_ctrl", alu_control, 3'b111);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_record", {wb_en, flag_we, branch_taken, illegal}, 4'b0000);
    chk("rst_z_flag", z_flag, 0);
    rst = 1'b0;
    step();

    run_op(5'b11000, 1'b0, 0);   // ADD
    run_op(5'b11110, 1'b0, 0);   // MUL
    run_op(5'b10110, 1'b1, 0);   // CMPR, zero -> z_flag=1
    run_op(5'b00111, 1'b0, 0);   // JEQ taken
    run_op(5'b00000, 1'b0, 0);   // illegal
    run_op(5'b11100, 1'b0, 5);   // remainder op with backpressure
    run_op(5'b10111, 1'b0, 0);   // CMPI, nonzero -> z_flag=0
    run_op(5'b00111, 1'b0, 0);   // JEQ not taken
    run_op(5'b00001, 1'b0, 0);   // JMP
    run_op(5'b11001, 1'b0, 1);   // LSR
    run_op(5'b10101, 1'b0, 0);   // MOVI
    run_op(5'b11010, 1'b0, 0);   // SUB
    run_op(5'b10110, 1'b1, 0);   // CMPR, z_flag=1 before the abort

    // Reset aborts a remainder op in its fourth EXEC cycle.
    chk("abort_idle_in_ready", in_ready, 1);
    in_opcode = 5'b11100;
    in_valid  = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step(); step();
    chk("abort_exec_ctrl", alu_control, 3'b011);
    #3;
    rst = 1'b1;
    #1;
    chk("abort_ctrl", alu_control, 3'b111);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_z_flag", z_flag, 0);
    model_z = 1'b0;
    step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("abort_no_record", out_valid, 0);
      step();
    end
    run_op(5'b11000, 1'b0, 0);   // ADD after abort

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
